// File: rtl/seg7_pkg.sv
// Shared constants for the multiplexed 7-segment scan driver: segment indices,
// the hex glyph table and the parameter legality check.
package seg7_pkg;

    localparam int SEG_A = 0;
    localparam int SEG_B = 1;
    localparam int SEG_C = 2;
    localparam int SEG_D = 3;
    localparam int SEG_E = 4;
    localparam int SEG_F = 5;
    localparam int SEG_G = 6;

    localparam int MAX_DIGITS      = 8;
    localparam int MIN_REFRESH_DIV = 4;

    // Active-high glyphs; literal bits read left to right as a..g.
    localparam logic [0:6] HEX_SEG [16] = '{
        7'b1111110,  // 0
        7'b0110000,  // 1
        7'b1101101,  // 2
        7'b1111001,  // 3
        7'b0110011,  // 4
        7'b1011011,  // 5
        7'b1011111,  // 6
        7'b1110000,  // 7
        7'b1111111,  // 8
        7'b1111011,  // 9
        7'b1110111,  // A
        7'b0011111,  // b
        7'b1001110,  // C
        7'b0111101,  // d
        7'b1001111,  // E
        7'b1000111   // F
    };

    function automatic bit cfg_legal(input int num_digits, input int refresh_div,
                                     input int dead_cycles);
        return (num_digits >= 1) && (num_digits <= MAX_DIGITS) &&
               (refresh_div >= MIN_REFRESH_DIV) &&
               (dead_cycles >= 0) && (dead_cycles < refresh_div);
    endfunction

endpackage

// File: rtl/seg7_decode.sv
// Hex nibble to active-high 7-segment pattern, with a blank override.
module seg7_decode
    import seg7_pkg::*;
(
    input  logic [3:0] nibble_i,
    input  logic       blank_i,
    output logic [0:6] seg_o
);

    always_comb begin
        seg_o = '0;
        for (int s = SEG_A; s <= SEG_G; s++) begin
            seg_o[s] = !blank_i && HEX_SEG[nibble_i][s];
        end
    end

endmodule

// File: rtl/seg7_scan_driver.sv
// Multiplexed 7-segment scanner: slot/digit counters, frame-synchronous
// double-buffered value, leading-zero blanking and registered polarity outputs.
module seg7_scan_driver
    import seg7_pkg::*;
#(
    parameter int NUM_DIGITS  = 4,
    parameter int REFRESH_DIV = 100000,
    parameter int DEAD_CYCLES = 2,
    parameter int ACTIVE_LOW  = 1
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    enable,
    input  logic                    load,
    input  logic [4*NUM_DIGITS-1:0] value,
    input  logic [NUM_DIGITS-1:0]   dp_in,
    input  logic                    lz_blank,
    output logic [0:6]              seg,
    output logic                    dp,
    output logic [NUM_DIGITS-1:0]   digit,
    output logic                    load_ack,
    output logic                    frame_done
);

    localparam int   SLOT_W = $clog2(REFRESH_DIV);
    localparam int   IDX_W  = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
    localparam logic POL    = (ACTIVE_LOW != 0);

    if (!cfg_legal(NUM_DIGITS, REFRESH_DIV, DEAD_CYCLES)) begin : g_bad_cfg
        $error("seg7_scan_driver: illegal NUM_DIGITS/REFRESH_DIV/DEAD_CYCLES");
    end

    logic [SLOT_W-1:0]       slot_q, slot_d;
    logic [IDX_W-1:0]        idx_q, idx_d;
    logic [4*NUM_DIGITS-1:0] pend_val_q, pend_val_d;
    logic [NUM_DIGITS-1:0]   pend_dp_q, pend_dp_d;
    logic                    pend_flag_q, pend_flag_d;
    logic [4*NUM_DIGITS-1:0] shad_val_q, shad_val_d;
    logic [NUM_DIGITS-1:0]   shad_dp_q, shad_dp_d;
    logic                    ack_q, ack_d;
    logic                    fdone_q, fdone_d;
    logic [0:6]              seg_q, seg_d;
    logic                    dp_q, dp_d;
    logic [NUM_DIGITS-1:0]   digit_q, digit_d;

    logic                    slot_tc, idx_tc, frame_end;
    logic [NUM_DIGITS:0]     zero_from;
    logic [3:0]              nib_sel;
    logic                    dp_sel, zero_sel, blank_sel, lit;
    logic [NUM_DIGITS-1:0]   digit_on;
    logic [0:6]              dec_seg;

    always_comb begin
        slot_tc   = (slot_q == SLOT_W'(REFRESH_DIV - 1));
        idx_tc    = (idx_q == IDX_W'(NUM_DIGITS - 1));
        frame_end = slot_tc && idx_tc;

        slot_d = slot_tc ? '0 : slot_q + SLOT_W'(1);
        idx_d  = idx_q;
        if (slot_tc) begin
            idx_d = idx_tc ? '0 : idx_q + IDX_W'(1);
        end

        // Shadow only moves at the frame edge so a frame never mixes two values;
        // a load in that same cycle lands in pending for the following frame.
        pend_val_d  = pend_val_q;
        pend_dp_d   = pend_dp_q;
        pend_flag_d = pend_flag_q;
        shad_val_d  = shad_val_q;
        shad_dp_d   = shad_dp_q;
        if (frame_end && pend_flag_q) begin
            shad_val_d  = pend_val_q;
            shad_dp_d   = pend_dp_q;
            pend_flag_d = 1'b0;
        end
        if (load) begin
            pend_val_d  = value;
            pend_dp_d   = dp_in;
            pend_flag_d = 1'b1;
        end

        ack_d   = frame_end && pend_flag_q;
        fdone_d = frame_end;
    end

    // zero_from[k]: nibble k and every nibble above it are zero.
    always_comb begin
        zero_from             = '0;
        zero_from[NUM_DIGITS] = 1'b1;
        for (int k = NUM_DIGITS - 1; k >= 0; k--) begin
            zero_from[k] = zero_from[k+1] && (shad_val_q[4*k +: 4] == 4'h0);
        end

        nib_sel  = '0;
        dp_sel   = 1'b0;
        zero_sel = 1'b0;
        for (int k = 0; k < NUM_DIGITS; k++) begin
            if (idx_q == IDX_W'(k)) begin
                nib_sel  = shad_val_q[4*k +: 4];
                dp_sel   = shad_dp_q[k];
                zero_sel = zero_from[k];
            end
        end
        blank_sel = lz_blank && (idx_q != '0) && zero_sel;
    end

    seg7_decode u_decode (
        .nibble_i (nib_sel),
        .blank_i  (blank_sel),
        .seg_o    (dec_seg)
    );

    always_comb begin
        lit      = enable && (int'(slot_q) >= DEAD_CYCLES);
        digit_on = '0;
        for (int k = 0; k < NUM_DIGITS; k++) begin
            digit_on[k] = lit && (idx_q == IDX_W'(k));
        end
        seg_d   = dec_seg ^ {7{POL}};
        dp_d    = dp_sel ^ POL;
        digit_d = digit_on ^ {NUM_DIGITS{POL}};
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            slot_q      <= '0;
            idx_q       <= '0;
            pend_val_q  <= '0;
            pend_dp_q   <= '0;
            pend_flag_q <= 1'b0;
            shad_val_q  <= '0;
            shad_dp_q   <= '0;
            ack_q       <= 1'b0;
            fdone_q     <= 1'b0;
            seg_q       <= {7{POL}};
            dp_q        <= POL;
            digit_q     <= {NUM_DIGITS{POL}};
        end else begin
            slot_q      <= slot_d;
            idx_q       <= idx_d;
            pend_val_q  <= pend_val_d;
            pend_dp_q   <= pend_dp_d;
            pend_flag_q <= pend_flag_d;
            shad_val_q  <= shad_val_d;
            shad_dp_q   <= shad_dp_d;
            ack_q       <= ack_d;
            fdone_q     <= fdone_d;
            seg_q       <= seg_d;
            dp_q        <= dp_d;
            digit_q     <= digit_d;
        end
    end

    assign seg        = seg_q;
    assign dp         = dp_q;
    assign digit      = digit_q;
    assign load_ack   = ack_q;
    assign frame_done = fdone_q;

endmodule
